// File: rtl/accelerator_vector_stream_feeder_if.sv
// Element-stream bundle between the vector feeder (slave) and its host/consumer side (master).
// Carries the operand load port, buffer status, stream start/finish and the paired A/B element stream.
interface accelerator_vector_stream_feeder_if #(
  parameter int DATA_SIZE = 64,
  parameter int ADDR_SIZE = 4
);
  logic                 LOAD_ENABLE;
  logic [DATA_SIZE-1:0] LOAD_A_IN;
  logic [DATA_SIZE-1:0] LOAD_B_IN;
  logic                 FULL;
  logic                 EMPTY;
  logic [ADDR_SIZE:0]   COUNT;
  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] LENGTH_OUT;
  logic                 ELEMENT_REQUEST;
  logic                 DATA_A_OUT_ENABLE;
  logic                 DATA_B_OUT_ENABLE;
  logic [DATA_SIZE-1:0] DATA_A_OUT;
  logic [DATA_SIZE-1:0] DATA_B_OUT;

  modport master (
    output LOAD_ENABLE, LOAD_A_IN, LOAD_B_IN, START, ELEMENT_REQUEST,
    input  FULL, EMPTY, COUNT, READY, LENGTH_OUT,
    input  DATA_A_OUT_ENABLE, DATA_B_OUT_ENABLE, DATA_A_OUT, DATA_B_OUT
  );

  modport slave (
    input  LOAD_ENABLE, LOAD_A_IN, LOAD_B_IN, START, ELEMENT_REQUEST,
    output FULL, EMPTY, COUNT, READY, LENGTH_OUT,
    output DATA_A_OUT_ENABLE, DATA_B_OUT_ENABLE, DATA_A_OUT, DATA_B_OUT
  );
endinterface

// File: rtl/accelerator_vector_stream_feeder.sv
// Buffers up to 2**ADDR_SIZE (A,B) operand pairs and streams them, one pair per consumer request.
// Define ACCELERATOR_VECTOR_FEEDER_REPLAY_EN to retain the buffer after each stream so START replays it.
module accelerator_vector_stream_feeder #(
  parameter int DATA_SIZE = 64,
  parameter int ADDR_SIZE = 4
) (
  input logic                               CLK,
  input logic                               RST,
  accelerator_vector_stream_feeder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0]   CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] IDX_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE:0]   count_q;   // also the write pointer: pairs always fill from address 0
  logic [ADDR_SIZE:0]   len_q;
  logic [ADDR_SIZE-1:0] rd_idx_q;
  logic                 ready_q;
  logic                 vld_p1;
  logic [DATA_SIZE-1:0] data_a_p1, data_b_p1;
  logic [DATA_SIZE-1:0] mem_a [DEPTH];
  logic [DATA_SIZE-1:0] mem_b [DEPTH];

  logic full, last_req;
  logic load_acc, start_acc, emit, finish;

  // count_q never exceeds DEPTH, so its MSB alone marks a full buffer
  assign full     = count_q[ADDR_SIZE];
  assign last_req = ({1'b0, rd_idx_q} == (len_q - CNT_ONE));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = (count_q != '0) ? STREAM : DONE;
      STREAM:  if (bus.ELEMENT_REQUEST && last_req) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A START wins over a load presented in the same cycle
  always_comb begin
    load_acc  = 1'b0;
    start_acc = 1'b0;
    emit      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        start_acc = bus.START;
        load_acc  = bus.LOAD_ENABLE && !full && !bus.START;
      end
      STREAM:  emit   = bus.ELEMENT_REQUEST;
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q  <= '0;
      len_q    <= '0;
      rd_idx_q <= '0;
      ready_q  <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      ready_q <= finish;
      vld_p1  <= emit;
      if (load_acc) count_q <= count_q + CNT_ONE;
      if (start_acc) begin
        len_q    <= count_q;
        rd_idx_q <= '0;
      end
      if (emit) rd_idx_q <= rd_idx_q + IDX_ONE;
      if (finish) begin
        rd_idx_q <= '0;
`ifdef ACCELERATOR_VECTOR_FEEDER_REPLAY_EN
        count_q  <= count_q;
`else
        count_q  <= '0;
`endif
      end
    end
  end

  // ---- stage p0 -> p1: buffer read into the output element registers ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_a_p1 <= '0;
      data_b_p1 <= '0;
    end else if (emit) begin
      data_a_p1 <= mem_a[rd_idx_q];
      data_b_p1 <= mem_b[rd_idx_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (load_acc) begin
      mem_a[count_q[ADDR_SIZE-1:0]] <= bus.LOAD_A_IN;
      mem_b[count_q[ADDR_SIZE-1:0]] <= bus.LOAD_B_IN;
    end
  end

  assign bus.FULL              = full;
  assign bus.EMPTY             = (count_q == '0);
  assign bus.COUNT             = count_q;
  assign bus.READY             = ready_q;
  assign bus.LENGTH_OUT        = {{(DATA_SIZE-ADDR_SIZE-1){1'b0}}, len_q};
  assign bus.DATA_A_OUT_ENABLE = vld_p1;
  assign bus.DATA_B_OUT_ENABLE = vld_p1;
  assign bus.DATA_A_OUT        = data_a_p1;
  assign bus.DATA_B_OUT        = data_b_p1;
endmodule

// File: tb/tb_accelerator_vector_stream_feeder.sv
// Scoreboard bench for accelerator_vector_stream_feeder: loads, streams, full/empty edges, async reset.
// Expected elements are queued when a request is driven and retired when the strobe is due.
module tb_accelerator_vector_stream_feeder;
  localparam int DS    = 64;
  localparam int AS    = 4;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  accelerator_vector_stream_feeder_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) bus ();

  accelerator_vector_stream_feeder #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DS-1:0] mdl_a[$], mdl_b[$];
  logic [DS-1:0] exp_a_q[$], exp_b_q[$];
  logic [DS-1:0] last_a, last_b;
  int mdl_len, mdl_idx;
  bit in_stream;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.LOAD_ENABLE     = 1'b0;
    bus.LOAD_A_IN       = '0;
    bus.LOAD_B_IN       = '0;
    bus.START           = 1'b0;
    bus.ELEMENT_REQUEST = 1'b0;
  endtask

  task automatic clear_model();
    mdl_a.delete(); mdl_b.delete();
    exp_a_q.delete(); exp_b_q.delete();
    mdl_len = 0; mdl_idx = 0; in_stream = 1'b0;
    last_a = '0; last_b = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    RST = 1'b1;
    #12;
    @(negedge CLK);
    RST = 1'b0;
    step();
    clear_model();
  endtask

  task automatic load_pair(input logic [DS-1:0] a, input logic [DS-1:0] b);
    bus.LOAD_ENABLE = 1'b1;
    bus.LOAD_A_IN   = a;
    bus.LOAD_B_IN   = b;
    if (mdl_a.size() < DEPTH) begin
      mdl_a.push_back(a);
      mdl_b.push_back(b);
    end
    step();
    clear_inputs();
    checks++;
    if (bus.COUNT !== (AS+1)'(mdl_a.size())) begin
      failures++;
      $display("FAIL load_count got=%0d exp=%0d", bus.COUNT, mdl_a.size());
    end
    checks++;
    if (bus.FULL !== (mdl_a.size() == DEPTH)) begin
      failures++;
      $display("FAIL load_full got=%0b exp=%0b", bus.FULL, mdl_a.size() == DEPTH);
    end
    checks++;
    if (bus.EMPTY !== 1'b0) begin
      failures++;
      $display("FAIL load_empty got=%0b exp=0", bus.EMPTY);
    end
  endtask

  task automatic start_stream();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    mdl_len   = mdl_a.size();
    mdl_idx   = 0;
    in_stream = (mdl_len > 0);
    checks++;
    if (bus.LENGTH_OUT !== DS'(mdl_len)) begin
      failures++;
      $display("FAIL start_length got=%0d exp=%0d", bus.LENGTH_OUT, mdl_len);
    end
    checks++;
    if (bus.DATA_A_OUT_ENABLE !== 1'b0 || bus.READY !== 1'b0) begin
      failures++;
      $display("FAIL start_quiet got en=%0b rdy=%0b exp en=0 rdy=0", bus.DATA_A_OUT_ENABLE, bus.READY);
    end
  endtask

  // One streaming cycle; loads and STARTs driven here must be ignored by the DUT
  task automatic stream_cycle(input bit req, input bit ld, input bit st);
    bit exp_en;
    exp_en = req && in_stream;
    if (exp_en) begin
      exp_a_q.push_back(mdl_a[mdl_idx]);
      exp_b_q.push_back(mdl_b[mdl_idx]);
      mdl_idx++;
      if (mdl_idx == mdl_len) in_stream = 1'b0;
    end
    bus.ELEMENT_REQUEST = req;
    bus.LOAD_ENABLE     = ld;
    bus.START           = st;
    bus.LOAD_A_IN       = {$urandom, $urandom};
    bus.LOAD_B_IN       = {$urandom, $urandom};
    step();
    clear_inputs();
    if (exp_en) begin
      last_a = exp_a_q.pop_front();
      last_b = exp_b_q.pop_front();
    end
    checks++;
    if (bus.DATA_A_OUT_ENABLE !== exp_en) begin
      failures++;
      $display("FAIL strobe_a got=%0b exp=%0b idx=%0d", bus.DATA_A_OUT_ENABLE, exp_en, mdl_idx);
    end
    checks++;
    if (bus.DATA_B_OUT_ENABLE !== exp_en) begin
      failures++;
      $display("FAIL strobe_b got=%0b exp=%0b idx=%0d", bus.DATA_B_OUT_ENABLE, exp_en, mdl_idx);
    end
    checks++;
    if (bus.DATA_A_OUT !== last_a || bus.DATA_B_OUT !== last_b) begin
      failures++;
      $display("FAIL stream_data got=%0h/%0h exp=%0h/%0h", bus.DATA_A_OUT, bus.DATA_B_OUT, last_a, last_b);
    end
    checks++;
    if (bus.READY !== 1'b0 || bus.COUNT !== (AS+1)'(mdl_a.size())) begin
      failures++;
      $display("FAIL stream_status got rdy=%0b cnt=%0d exp rdy=0 cnt=%0d", bus.READY, bus.COUNT, mdl_a.size());
    end
  endtask

  // DONE cycle: READY pulse, buffer cleared unless replay keeps it
  task automatic finish_stream(input bit req);
    bus.ELEMENT_REQUEST = req;
    step();
    clear_inputs();
`ifndef ACCELERATOR_VECTOR_FEEDER_REPLAY_EN
    mdl_a.delete();
    mdl_b.delete();
`endif
    checks++;
    if (bus.READY !== 1'b1) begin
      failures++;
      $display("FAIL ready_pulse got=%0b exp=1", bus.READY);
    end
    checks++;
    if (bus.DATA_A_OUT_ENABLE !== 1'b0 || bus.DATA_B_OUT_ENABLE !== 1'b0) begin
      failures++;
      $display("FAIL done_strobe got=%0b/%0b exp=0/0", bus.DATA_A_OUT_ENABLE, bus.DATA_B_OUT_ENABLE);
    end
    checks++;
    if (bus.COUNT !== (AS+1)'(mdl_a.size()) || bus.EMPTY !== (mdl_a.size() == 0)) begin
      failures++;
      $display("FAIL done_count got cnt=%0d empty=%0b exp cnt=%0d", bus.COUNT, bus.EMPTY, mdl_a.size());
    end
    checks++;
    if (bus.LENGTH_OUT !== DS'(mdl_len)) begin
      failures++;
      $display("FAIL done_length got=%0d exp=%0d", bus.LENGTH_OUT, mdl_len);
    end
    step();
    checks++;
    if (bus.READY !== 1'b0) begin
      failures++;
      $display("FAIL ready_width got=%0b exp=0", bus.READY);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.COUNT !== '0 || bus.EMPTY !== 1'b1 || bus.FULL !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got cnt=%0d e=%0b f=%0b exp 0/1/0", bus.COUNT, bus.EMPTY, bus.FULL);
    end
    checks++;
    if (bus.READY !== 1'b0 || bus.DATA_A_OUT_ENABLE !== 1'b0 || bus.DATA_B_OUT_ENABLE !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got rdy=%0b en=%0b/%0b exp 0", bus.READY, bus.DATA_A_OUT_ENABLE, bus.DATA_B_OUT_ENABLE);
    end
    checks++;
    if (bus.DATA_A_OUT !== '0 || bus.DATA_B_OUT !== '0 || bus.LENGTH_OUT !== '0) begin
      failures++;
      $display("FAIL reset_data got a=%0h b=%0h len=%0d exp 0", bus.DATA_A_OUT, bus.DATA_B_OUT, bus.LENGTH_OUT);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    load_pair(64'd1, 64'd10);
    load_pair(64'd2, 64'd20);
    load_pair(64'd3, 64'd30);
    start_stream();
    for (int i = 0; i < 3; i++) stream_cycle(1'b1, 1'b0, 1'b0);
    finish_stream(1'b0);
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++) load_pair({$urandom, $urandom}, {$urandom, $urandom});
    start_stream();
    for (int i = 0; i < DEPTH; i++) stream_cycle(1'b1, 1'b0, 1'b0);
    finish_stream(1'b1);
  endtask

  task automatic test_empty_start();
    apply_reset();
    start_stream();
    finish_stream(1'b1);
  endtask

  task automatic test_spaced();
    apply_reset();
    for (int i = 0; i < 4; i++) load_pair(64'(100 + i), 64'(200 + i));
    start_stream();
    stream_cycle(1'b1, 1'b0, 1'b0);
    stream_cycle(1'b1, 1'b0, 1'b0);
    stream_cycle(1'b0, 1'b1, 1'b0);
    stream_cycle(1'b0, 1'b0, 1'b1);
    stream_cycle(1'b0, 1'b1, 1'b1);
    stream_cycle(1'b1, 1'b0, 1'b0);
    stream_cycle(1'b0, 1'b1, 1'b0);
    stream_cycle(1'b1, 1'b0, 1'b0);
    finish_stream(1'b0);
  endtask

  task automatic test_reset_mid_stream();
    apply_reset();
    for (int i = 0; i < 5; i++) load_pair(64'(i + 50), 64'(i + 60));
    start_stream();
    stream_cycle(1'b1, 1'b0, 1'b0);
    stream_cycle(1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    checks++;
    if (bus.DATA_A_OUT_ENABLE !== 1'b0 || bus.DATA_B_OUT_ENABLE !== 1'b0 || bus.READY !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_ctrl got en=%0b/%0b rdy=%0b exp 0", bus.DATA_A_OUT_ENABLE, bus.DATA_B_OUT_ENABLE, bus.READY);
    end
    checks++;
    if (bus.DATA_A_OUT !== '0 || bus.DATA_B_OUT !== '0 || bus.LENGTH_OUT !== '0) begin
      failures++;
      $display("FAIL async_rst_data got a=%0h b=%0h len=%0d exp 0", bus.DATA_A_OUT, bus.DATA_B_OUT, bus.LENGTH_OUT);
    end
    checks++;
    if (bus.COUNT !== '0 || bus.EMPTY !== 1'b1 || bus.FULL !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_status got cnt=%0d e=%0b f=%0b exp 0/1/0", bus.COUNT, bus.EMPTY, bus.FULL);
    end
    @(negedge CLK);
    RST = 1'b0;
    step();
    clear_model();
    start_stream();
    finish_stream(1'b0);
  endtask

`ifdef ACCELERATOR_VECTOR_FEEDER_REPLAY_EN
  task automatic test_replay();
    apply_reset();
    load_pair(64'd7, 64'd1);
    load_pair(64'd8, 64'd2);
    for (int pass = 0; pass < 2; pass++) begin
      start_stream();
      stream_cycle(1'b1, 1'b0, 1'b0);
      stream_cycle(1'b1, 1'b0, 1'b0);
      finish_stream(1'b0);
    end
    load_pair(64'd9, 64'd3);
  endtask
`endif

  initial begin
    clear_inputs();
    clear_model();
    test_reset();
    test_basic();
    test_full();
    test_empty_start();
    test_spaced();
    test_reset_mid_stream();
`ifdef ACCELERATOR_VECTOR_FEEDER_REPLAY_EN
    test_replay();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
